// File: rtl/adt7301_reader.sv
// adt7301_reader: SPI read master that scans the board's ADT7301 sensors.
// A scan selects each enabled sensor in ascending index order, clocks one
// 16-bit frame out of it, and reports the 14-bit temperature with its index.
module adt7301_reader #(
  parameter int CLK_DIV = 4,
  parameter int N_SENS  = 3
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              start,
  input  logic [N_SENS-1:0] sens_en,
  output logic              busy,
  output logic [13:0]       temp_data,
  output logic [1:0]        temp_idx,
  output logic              temp_valid,
  output logic [N_SENS-1:0] adt_cs_b,
  output logic              adt_sclk,
  output logic              adt_din,
  input  logic              adt_dout
);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  localparam logic [7:0]        DIV_M1 = 8'(CLK_DIV - 1);
  localparam logic [N_SENS-1:0] ONE    = N_SENS'(1);

  state_t            r_state;
  logic [7:0]        r_cnt;
  logic [3:0]        r_bitCnt;
  logic [N_SENS-1:0] r_en;
  logic [1:0]        r_idx;
  logic [N_SENS-1:0] r_csB;
  logic              r_sclk;
  logic              r_busy;
  logic              r_valid;
  logic [13:0]       r_data;
  logic [1:0]        r_tempIdx;
  // Only 14 bits are kept: after 16 shifts the two header bits have
  // already fallen off the top, leaving exactly the temperature field.
  logic [13:0]       r_shift;

  logic [1:0]        w_firstIdx;
  logic [1:0]        w_nextIdx;
  logic              w_nextFound;

  // Lowest enabled sensor at scan start, and the next higher one mid-scan.
  always_comb begin
    w_firstIdx  = '0;
    w_nextIdx   = '0;
    w_nextFound = 1'b0;
    for (int i = N_SENS - 1; i >= 0; i--) begin
      if (sens_en[i]) begin
        w_firstIdx = 2'(i);
      end
      if (r_en[i] && (2'(i) > r_idx)) begin
        w_nextIdx   = 2'(i);
        w_nextFound = 1'b1;
      end
    end
  end

  // Scan sequencer: CS setup, 16 SCLK periods per frame, inter-sensor gap.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bitCnt  <= '0;
      r_en      <= '0;
      r_idx     <= '0;
      r_csB     <= '1;
      r_sclk    <= 1'b1;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_tempIdx <= '0;
      r_shift   <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && (sens_en != '0)) begin
            r_en    <= sens_en;
            r_idx   <= w_firstIdx;
            r_csB   <= ~(ONE << w_firstIdx);
            r_busy  <= 1'b1;
            r_cnt   <= DIV_M1;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          if (r_cnt == 8'd0) begin
            r_sclk   <= 1'b0;
            r_cnt    <= DIV_M1;
            r_bitCnt <= '0;
            r_state  <= SHIFT;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        SHIFT: begin
          if (r_cnt == 8'd0) begin
            r_cnt <= DIV_M1;
            if (!r_sclk) begin
              r_sclk  <= 1'b1;
              r_shift <= {r_shift[12:0], adt_dout};
            end else if (r_bitCnt == 4'd15) begin
              r_csB     <= '1;
              r_data    <= r_shift;
              r_tempIdx <= r_idx;
              r_valid   <= 1'b1;
              r_state   <= GAP;
            end else begin
              r_sclk   <= 1'b0;
              r_bitCnt <= r_bitCnt + 4'd1;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        GAP: begin
          if (r_cnt == 8'd0) begin
            if (w_nextFound) begin
              r_idx   <= w_nextIdx;
              r_csB   <= ~(ONE << w_nextIdx);
              r_cnt   <= DIV_M1;
              r_state <= SETUP;
            end else begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign temp_data  = r_data;
  assign temp_idx   = r_tempIdx;
  assign temp_valid = r_valid;
  assign adt_cs_b   = r_csB;
  assign adt_sclk   = r_sclk;
  assign adt_din    = 1'b0;

endmodule

// File: tb/tb_adt7301_reader.sv
// tb_adt7301_reader: directed bench for adt7301_reader with sensor models.
module tb_adt7301_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_b, start, start2;
  logic [2:0]  sens_en, sens_en2;
  logic        busy, busy2, temp_valid, temp_valid2;
  logic [13:0] temp_data, temp_data2;
  logic [1:0]  temp_idx, temp_idx2;
  logic [2:0]  adt_cs_b, adt_cs_b2;
  logic        adt_sclk, adt_sclk2, adt_din, adt_din2;
  logic        adt_dout  = 1'b0;
  logic        adt_dout2 = 1'b0;

  int total = 0;
  int bad   = 0;
  int edgeCnt = 0;
  int e0;

  adt7301_reader #(.CLK_DIV(4), .N_SENS(3)) u_dut (
    .clk(clk), .rst_b(rst_b), .start(start), .sens_en(sens_en), .busy(busy),
    .temp_data(temp_data), .temp_idx(temp_idx), .temp_valid(temp_valid),
    .adt_cs_b(adt_cs_b), .adt_sclk(adt_sclk), .adt_din(adt_din), .adt_dout(adt_dout)
  );

  adt7301_reader #(.CLK_DIV(2), .N_SENS(3)) u_dut2 (
    .clk(clk), .rst_b(rst_b), .start(start2), .sens_en(sens_en2), .busy(busy2),
    .temp_data(temp_data2), .temp_idx(temp_idx2), .temp_valid(temp_valid2),
    .adt_cs_b(adt_cs_b2), .adt_sclk(adt_sclk2), .adt_din(adt_din2), .adt_dout(adt_dout2)
  );

  // Rising-edge index, used to time every observed event.
  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  // Sensor model: presents the next frame bit on each SCLK falling edge.
  logic [15:0] frames [3];
  int bitPos = 0;
  always @(negedge adt_sclk) begin
    if (adt_cs_b != 3'b111 && bitPos < 16) begin
      for (int i = 0; i < 3; i++)
        if (!adt_cs_b[i]) adt_dout = frames[i][15 - bitPos];
      bitPos++;
    end
  end
  always @(adt_cs_b) if (adt_cs_b == 3'b111) bitPos = 0;

  logic [15:0] frame2 = 16'h2000;
  int bitPos2 = 0;
  always @(negedge adt_sclk2) begin
    if (!adt_cs_b2[0] && bitPos2 < 16) begin
      adt_dout2 = frame2[15 - bitPos2];
      bitPos2++;
    end
  end
  always @(adt_cs_b2) if (adt_cs_b2 == 3'b111) bitPos2 = 0;

  // Event recorder for the CLK_DIV=4 instance.
  logic        prevSclk = 1'b1, prevBusy = 1'b0;
  logic [2:0]  prevCs = 3'b111;
  int          vCount, busyFall, busyRises, overlap, idleToggle;
  int          vEdge [8];
  logic [13:0] vData [8];
  logic [1:0]  vIdx [8];
  int          rises [3];
  int          csFalls [3];
  always @(negedge clk) begin
    if (temp_valid) begin
      if (vCount < 8) begin
        vEdge[vCount] = edgeCnt;
        vData[vCount] = temp_data;
        vIdx[vCount]  = temp_idx;
      end
      vCount++;
    end
    if (prevBusy && !busy) busyFall = edgeCnt;
    if (!prevBusy && busy) busyRises++;
    if ($countones(~adt_cs_b) > 1) overlap++;
    if (adt_sclk != prevSclk) begin
      if (adt_cs_b == 3'b111) idleToggle++;
      else if (adt_sclk)
        for (int i = 0; i < 3; i++) if (!adt_cs_b[i]) rises[i]++;
    end
    for (int i = 0; i < 3; i++) if (prevCs[i] && !adt_cs_b[i]) csFalls[i]++;
    prevSclk = adt_sclk;
    prevBusy = busy;
    prevCs   = adt_cs_b;
  end

  // Event recorder for the CLK_DIV=2 instance, including SCLK phase lengths.
  logic        prevSclk2 = 1'b1, prevBusy2 = 1'b0;
  int          vCount2, vEdge2, busyFall2, rises2, phaseCnt2, phaseErr2, lastToggle2;
  logic [13:0] vData2;
  logic [1:0]  vIdx2;
  always @(negedge clk) begin
    if (temp_valid2) begin
      vCount2++;
      vEdge2 = edgeCnt;
      vData2 = temp_data2;
      vIdx2  = temp_idx2;
    end
    if (prevBusy2 && !busy2) busyFall2 = edgeCnt;
    if (adt_sclk2 != prevSclk2 && adt_cs_b2 != 3'b111) begin
      if (adt_sclk2) rises2++;
      if (lastToggle2 >= 0) begin
        phaseCnt2++;
        if (edgeCnt - lastToggle2 != 2) phaseErr2++;
      end
      lastToggle2 = edgeCnt;
    end
    if (adt_cs_b2 == 3'b111) lastToggle2 = -1;
    prevSclk2 = adt_sclk2;
    prevBusy2 = busy2;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic waitUntil(input int t);
    while (edgeCnt < t) waitCycles(1);
  endtask

  task automatic clearStats();
    vCount = 0; busyFall = -1; busyRises = 0; overlap = 0; idleToggle = 0;
    for (int i = 0; i < 3; i++) begin
      rises[i] = 0;
      csFalls[i] = 0;
    end
    for (int i = 0; i < 8; i++) begin
      vEdge[i] = -1;
      vData[i] = '0;
      vIdx[i]  = '0;
    end
  endtask

  // One-cycle start pulse; returns the edge at which it is sampled.
  task automatic applyStimulus(input logic [2:0] en, output int accEdge);
    start   = 1'b1;
    sens_en = en;
    accEdge = edgeCnt + 1;
    waitCycles(1);
    start = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_b = 1'b0; start = 1'b0; sens_en = '0; start2 = 1'b0; sens_en2 = '0;
    frames[0] = 16'h0320; frames[1] = 16'h3FF0; frames[2] = 16'h1FFF;

    waitCycles(3);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_cs", 32'(adt_cs_b), 32'h7);
    checkOutput("rst_sclk", 32'(adt_sclk), 32'd1);
    checkOutput("rst_din", 32'(adt_din), 32'd0);
    checkOutput("rst_valid", 32'(temp_valid), 32'd0);
    checkOutput("rst_data", 32'(temp_data), 32'd0);
    checkOutput("rst_idx", 32'(temp_idx), 32'd0);
    rst_b = 1'b1;
    waitCycles(2);
    $display("[TB] full scan sens_en=111");
    clearStats();
    applyStimulus(3'b111, e0);
    checkOutput("scan_busy_e0", 32'(busy), 32'd1);
    checkOutput("scan_cs_e0", 32'(adt_cs_b), 32'h6);
    waitUntil(e0 + 420);
    checkOutput("scan_vcount", vCount, 3);
    checkOutput("scan_v0_edge", vEdge[0], e0 + 132);
    checkOutput("scan_v1_edge", vEdge[1], e0 + 268);
    checkOutput("scan_v2_edge", vEdge[2], e0 + 404);
    checkOutput("scan_v0_data", 32'(vData[0]), 32'h0320);
    checkOutput("scan_v1_data", 32'(vData[1]), 32'h3FF0);
    checkOutput("scan_v2_data", 32'(vData[2]), 32'h1FFF);
    checkOutput("scan_v0_idx", 32'(vIdx[0]), 32'd0);
    checkOutput("scan_v1_idx", 32'(vIdx[1]), 32'd1);
    checkOutput("scan_v2_idx", 32'(vIdx[2]), 32'd2);
    checkOutput("scan_busy_fall", busyFall, e0 + 408);
    checkOutput("scan_rises0", rises[0], 16);
    checkOutput("scan_rises1", rises[1], 16);
    checkOutput("scan_rises2", rises[2], 16);
    checkOutput("scan_overlap", overlap, 0);
    checkOutput("scan_idle_sclk", idleToggle, 0);

    $display("[TB] skip disabled sensors sens_en=100");
    clearStats();
    applyStimulus(3'b100, e0);
    waitUntil(e0 + 150);
    checkOutput("skip_vcount", vCount, 1);
    checkOutput("skip_v0_edge", vEdge[0], e0 + 132);
    checkOutput("skip_v0_idx", 32'(vIdx[0]), 32'd2);
    checkOutput("skip_v0_data", 32'(vData[0]), 32'h1FFF);
    checkOutput("skip_busy_fall", busyFall, e0 + 136);
    checkOutput("skip_cs0_falls", csFalls[0], 0);
    checkOutput("skip_cs1_falls", csFalls[1], 0);
    checkOutput("skip_cs2_falls", csFalls[2], 1);

    $display("[TB] start with sens_en=000");
    clearStats();
    applyStimulus(3'b000, e0);
    waitCycles(40);
    checkOutput("none_busy", 32'(busy), 32'd0);
    checkOutput("none_busy_rises", busyRises, 0);
    checkOutput("none_cs_falls", csFalls[0] + csFalls[1] + csFalls[2], 0);
    checkOutput("none_sclk", idleToggle, 0);

    $display("[TB] start pulses during a scan");
    clearStats();
    applyStimulus(3'b111, e0);
    waitUntil(e0 + 9);
    start = 1'b1; sens_en = 3'b001;
    waitCycles(1);
    start = 1'b0;
    waitUntil(e0 + 199);
    start = 1'b1; sens_en = 3'b010;
    waitCycles(1);
    start = 1'b0;
    waitUntil(e0 + 420);
    checkOutput("busy_vcount", vCount, 3);
    checkOutput("busy_v0_edge", vEdge[0], e0 + 132);
    checkOutput("busy_v1_edge", vEdge[1], e0 + 268);
    checkOutput("busy_v2_edge", vEdge[2], e0 + 404);
    checkOutput("busy_v2_idx", 32'(vIdx[2]), 32'd2);
    checkOutput("busy_busy_fall", busyFall, e0 + 408);
    checkOutput("busy_busy_rises", busyRises, 1);

    $display("[TB] reset mid-frame");
    clearStats();
    applyStimulus(3'b111, e0);
    waitUntil(e0 + 59);
    rst_b = 1'b0;
    waitCycles(1);
    checkOutput("mid_cs", 32'(adt_cs_b), 32'h7);
    checkOutput("mid_sclk", 32'(adt_sclk), 32'd1);
    checkOutput("mid_busy", 32'(busy), 32'd0);
    rst_b = 1'b1;
    waitCycles(200);
    checkOutput("mid_no_valid", vCount, 0);
    clearStats();
    frames[1] = 16'hC123;
    applyStimulus(3'b010, e0);
    waitUntil(e0 + 150);
    checkOutput("mid_fresh_vcount", vCount, 1);
    checkOutput("mid_fresh_edge", vEdge[0], e0 + 132);
    checkOutput("mid_fresh_data", 32'(vData[0]), 32'h0123);
    checkOutput("mid_fresh_idx", 32'(vIdx[0]), 32'd1);
    checkOutput("mid_fresh_rises", rises[1], 16);
    checkOutput("mid_fresh_busy_fall", busyFall, e0 + 136);

    $display("[TB] CLK_DIV=2 single sensor");
    vCount2 = 0; vEdge2 = -1; busyFall2 = -1; rises2 = 0;
    phaseCnt2 = 0; phaseErr2 = 0; lastToggle2 = -1; vData2 = '0; vIdx2 = 2'd3;
    start2 = 1'b1; sens_en2 = 3'b001;
    e0 = edgeCnt + 1;
    waitCycles(1);
    start2 = 1'b0;
    waitUntil(e0 + 80);
    checkOutput("div2_vcount", vCount2, 1);
    checkOutput("div2_edge", vEdge2, e0 + 66);
    checkOutput("div2_data", 32'(vData2), 32'h2000);
    checkOutput("div2_idx", 32'(vIdx2), 32'd0);
    checkOutput("div2_busy_fall", busyFall2, e0 + 68);
    checkOutput("div2_rises", rises2, 16);
    checkOutput("div2_phase_cnt", phaseCnt2, 31);
    checkOutput("div2_phase_err", phaseErr2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adt7301_reader.md
# adt7301_reader

SPI read master for the board's three ADT7301 temperature sensors, the FPGA-side reader for the sensors' serial output. On each scan request it selects every enabled sensor in turn and clocks out one 16-bit frame per sensor. It returns the 14-bit two's-complement temperature (1/32 °C per LSB) with the sensor index. It sits between the board-management register block and the ADT_CS_B / ADT_SCLK / ADT_DIN / ADT_DOUT pins.

## Interface
- CLK_DIV, 4: clk cycles per SCLK half-period; legal range 2..255.
- N_SENS, 3: number of sensors (chip selects).
- clk  in  1  system clock; all logic on rising edge.
- rst_b  in  1  synchronous active-low reset.
- start  in  1  one-cycle scan request.
- sens_en  in  N_SENS  per-sensor enable; sampled when start is accepted.
- busy  out  1  scan in progress.
- temp_data  out  14  last temperature read, two's complement.
- temp_idx  out  2  sensor index belonging to temp_data.
- temp_valid  out  1  one-cycle strobe; temp_data/temp_idx valid.
- adt_cs_b  out  N_SENS  active-low chip selects.
- adt_sclk  out  1  serial clock, idles high.
- adt_din  out  1  held 0 (normal conversion mode).
- adt_dout  in  1  sensor serial data.

## Operation
- Reset values: busy=0, adt_cs_b=all 1, adt_sclk=1, adt_din=0, temp_valid=0, temp_data=0, temp_idx=0, FSM=IDLE.
- FSM states: IDLE, SETUP, SHIFT, GAP.
- IDLE:
  - start=1 with sens_en≠0: latch sens_en, select the lowest enabled index, set busy=1, drive that CS low, go to SETUP.
  - start=1 with sens_en=0: ignored; busy stays 0.
- start while busy=1 is ignored. sens_en changes during a scan have no effect.
- SETUP: CLK_DIV cycles with CS low and SCLK high. adt_sclk then falls; go to SHIFT.
- SHIFT: 16 bits, MSB first. Each bit has SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - adt_dout is captured into the shift register on the clk edge that drives adt_sclk 0→1.
  - The sensor updates data on the falling edge, so no synchronizer is needed.
- After the 16th high phase: CS goes high, temp_data=shift[13:0] (bits 15:14 discarded), temp_idx=current index, temp_valid=1 for one cycle. Go to GAP.
- GAP: CLK_DIV cycles with all CS high. Then either:
  - next higher enabled index exists: assert its CS and go to SETUP;
  - otherwise: busy=0 and go to IDLE.
- Only one CS is ever low at a time. adt_sclk toggles only while a CS is low.
- rst_b low mid-frame: on the next edge all outputs return to reset values. No temp_valid is produced for the partial frame.

## Timing
- Start accepted at edge E0: busy=1 and CS low at E0.
- Falling SCLK edges at E0+CLK_DIV+2k·CLK_DIV; rising edges (samples) at E0+CLK_DIV+(2k+1)·CLK_DIV, for k=0..15.
- Last sample at E0+32·CLK_DIV. CS high and temp_valid=1 at E0+33·CLK_DIV.
- Next sensor's CS low at E0+34·CLK_DIV.
- A scan of n enabled sensors ends (busy=0) at E0+n·34·CLK_DIV.
- With CLK_DIV=4: frame period 136 cycles; first temp_valid at E0+132; a full 3-sensor scan drops busy at E0+408.
- SCLK frequency = f_clk/(2·CLK_DIV). CS setup and hold to SCLK are CLK_DIV cycles each.

## Test plan
- Full scan, CLK_DIV=4, sens_en=3'b111:
  - sensor model returns 0x0320, 0x3FF0, 0x1FFF for indices 0, 1, 2;
  - required: temp_valid at E0+132, +268, +404 carrying (0x0320, idx 0), (0x3FF0, idx 1), (0x1FFF, idx 2);
  - busy falls at E0+408; exactly 16 SCLK rising edges per CS window.
- Skip disabled sensors, sens_en=3'b100:
  - required: only adt_cs_b[2] toggles; one temp_valid with idx 2 at E0+132; busy low at E0+136.
- start with sens_en=0:
  - required: busy stays 0, no CS or SCLK activity.
- start pulses at E0+10 and E0+200 during a 3-sensor scan:
  - required: both ignored; exactly 3 temp_valid pulses; timing identical to the full-scan case.
- rst_b low at E0+60 for 1 cycle:
  - required: next edge shows adt_cs_b=3'b111, adt_sclk=1, busy=0;
  - no temp_valid follows;
  - a fresh start afterwards reads correct data.
- CLK_DIV=2, sens_en=3'b001, sensor returns 0x2000 (−256 °C code):
  - required: temp_data=0x2000 with temp_valid at E0+66;
  - SCLK high and low phases are 2 cycles each.
